// File: rtl/timer_pkg.sv
// Shared constants for the timer CPU read/alarm path.
// Address nibbles and STATUS bit positions.
package timer_pkg;

  localparam logic [3:0] TMR_HOUR  = 4'h8;
  localparam logic [3:0] TMR_MIN   = 4'h9;
  localparam logic [3:0] TMR_AHOUR = 4'hA;
  localparam logic [3:0] TMR_AMIN  = 4'hB;
  localparam logic [3:0] TMR_STAT  = 4'hC;

  localparam int ST_PEND = 0;
  localparam int ST_EN   = 1;
  localparam int ST_SNAP = 2;

endpackage

// File: rtl/timer_alarm.sv
// Alarm registers, edge-detected match, sticky pending and
// the level interrupt derived from it.
module timer_alarm
  import timer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [5:0]        hour,
  input  logic [5:0]        minute,
  input  logic              we_ahour,
  input  logic              we_amin,
  input  logic              we_stat,
  input  logic [DATA_W-1:0] wdata,
  output logic [5:0]        alarm_hour,
  output logic [5:0]        alarm_min,
  output logic              alarm_en,
  output logic              pending,
  output logic              irq
);

  logic [5:0] ahour_q, ahour_d;
  logic [5:0] amin_q, amin_d;
  logic       en_q, en_d;
  logic       pend_q, pend_d;
  logic       mprev_q, mprev_d;
  logic       irq_q, irq_d;
  logic       match;
  logic       trig;
  logic       w1c;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:6];

  always_comb begin
    match   = (hour == ahour_q) && (minute == amin_q);
    trig    = en_q && match && !mprev_q;
    w1c     = we_stat && wdata[ST_PEND];
    mprev_d = match;
    ahour_d = we_ahour ? wdata[5:0] : ahour_q;
    amin_d  = we_amin ? wdata[5:0] : amin_q;
    en_d    = we_stat ? wdata[ST_EN] : en_q;
    // a new trigger beats a simultaneous clear
    pend_d  = trig || (pend_q && !w1c);
    irq_d   = pend_d && en_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ahour_q <= '0;
      amin_q  <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      mprev_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ahour_q <= ahour_d;
      amin_q  <= amin_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      mprev_q <= mprev_d;
      irq_q   <= irq_d;
    end
  end

  assign alarm_hour = ahour_q;
  assign alarm_min  = amin_q;
  assign alarm_en   = en_q;
  assign pending    = pend_q;
  assign irq        = irq_q;

endmodule

// File: rtl/timer_readback.sv
// CPU read responder for the time-of-day counter with a
// coherent hour/minute snapshot and a programmable alarm.
module timer_readback
  import timer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              r_en_n,
  input  logic              w_en_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [5:0]        hour,
  input  logic [5:0]        minute,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              irq
);

  logic [3:0]        nib;
  logic              rd, we;
  logic              sel_hour, sel_min;
  logic              sel_ahour, sel_amin, sel_stat;
  logic [5:0]        alarm_hour, alarm_min;
  logic              alarm_en, pending;
  logic [DATA_W-1:0] rdata_q, rdata_d, rmux;
  logic              rvalid_q, rvalid_d;
  logic              snapv_q, snapv_d;
  logic [5:0]        snapm_q, snapm_d;
  logic              unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:4];
  assign nib = addr[3:0];
  assign we  = !w_en_n;
  assign rd  = !r_en_n && w_en_n;

  assign sel_hour  = (nib == TMR_HOUR);
  assign sel_min   = (nib == TMR_MIN);
  assign sel_ahour = (nib == TMR_AHOUR);
  assign sel_amin  = (nib == TMR_AMIN);
  assign sel_stat  = (nib == TMR_STAT);

  timer_alarm #(
    .DATA_W (DATA_W)
  ) u_alarm (
    .clock      (clock),
    .rst_n      (rst_n),
    .hour       (hour),
    .minute     (minute),
    .we_ahour   (we && sel_ahour),
    .we_amin    (we && sel_amin),
    .we_stat    (we && sel_stat),
    .wdata      (wdata),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .pending    (pending),
    .irq        (irq)
  );

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_hour:  rmux[5:0] = hour;
      sel_min:   rmux[5:0] = snapv_q ? snapm_q : minute;
      sel_ahour: rmux[5:0] = alarm_hour;
      sel_amin:  rmux[5:0] = alarm_min;
      sel_stat: begin
        rmux[ST_PEND] = pending;
        rmux[ST_EN]   = alarm_en;
        rmux[ST_SNAP] = snapv_q;
      end
      default:   rmux = '0;
    endcase
  end

  always_comb begin
    rvalid_d = rd;
    rdata_d  = rd ? rmux : rdata_q;
    snapv_d  = snapv_q;
    snapm_d  = snapm_q;
    // hour read freezes minute so the pair reads coherently
    if (rd && sel_hour) begin
      snapv_d = 1'b1;
      snapm_d = minute;
    end
    if (rd && sel_min) snapv_d = 1'b0;
    if (we && (sel_hour || sel_min)) snapv_d = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      snapv_q  <= 1'b0;
      snapm_q  <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      snapv_q  <= snapv_d;
      snapm_q  <= snapm_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule
